// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_stall_ctrl_pkg;
    localparam int DIV_CYCLES_DEFAULT = 34;
    localparam int REG_IDX_W          = 5;
    localparam int DIV_CNT_W          = 6;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DIV_BUSY   = 2'd1,
        ST_FLUSH_PEND = 2'd2
    } stall_state_e;
endpackage

// File: rtl/pipeline_stall_ctrl_div_occupancy_cnt.sv
// Divider occupancy counter: loads DIV_CYCLES-1, counts down while running,
// flags the final cycle.
module div_occupancy_cnt
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    input  logic abort,
    output logic done
);
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (abort)
            cnt_d = '0;
        else if (load)
            cnt_d = DIV_CNT_W'(DIV_CYCLES - 1);
        else if (run && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done = run && (cnt_q == '0);
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard stall/flush controller for a 5-stage pipeline with a multicycle divider.
// Optional stalled-cycle counter enabled by defining STALL_PERF_CNT_EN.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_stall,
    input  logic                 d_stall,
    input  logic                 mem_readE,
    input  logic [REG_IDX_W-1:0] rtE,
    input  logic [REG_IDX_W-1:0] rsD,
    input  logic [REG_IDX_W-1:0] rtD,
    input  logic                 div_startE,
    input  logic                 branch_mispredE,
    input  logic                 exceptM,
    output logic                 stallF,
    output logic                 stallD,
    output logic                 stallE,
    output logic                 stallM,
    output logic                 stallW,
    output logic                 flushD,
    output logic                 flushE,
    output logic                 flushM,
    output logic                 flushW,
    output logic                 div_busy,
    output logic                 div_done,
    output logic [31:0]          stall_cycles
);
    stall_state_e state_q, state_d;

    logic miss, load_use, in_div, in_pend, exc_flush;
    logic div_load, div_run, div_abort;
    logic [4:0] stall_raw;
    logic [3:0] flush_raw;

    assign miss      = i_stall | d_stall;
    assign load_use  = mem_readE && rtE != '0 && (rtE == rsD || rtE == rtD);
    assign in_div    = (state_q == ST_DIV_BUSY);
    assign in_pend   = (state_q == ST_FLUSH_PEND);
    assign exc_flush = !miss && (exceptM || in_pend);
    assign div_load  = (state_q == ST_IDLE) && div_startE && !miss && !exceptM;
    assign div_run   = in_div && !miss && !exceptM;
    assign div_abort = in_div && exceptM;

    div_occupancy_cnt #(.DIV_CYCLES(DIV_CYCLES)) u_div_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (div_load),
        .run   (div_run),
        .abort (div_abort),
        .done  (div_done)
    );

    assign div_busy = in_div;

    // Highest-priority source wins outright; lower sources are ignored that cycle.
    always_comb begin
        stall_raw = '0;
        flush_raw = '0;
        if (miss)
            stall_raw = 5'b11111;
        else if (exc_flush)
            flush_raw = 4'b1111;
        else if (in_div && !div_done) begin
            stall_raw = 5'b11100;
            flush_raw = 4'b0010;
        end else if (load_use) begin
            stall_raw = 5'b11000;
            flush_raw = 4'b0100;
        end else if (branch_mispredE)
            flush_raw = 4'b1000;
    end

    assign stallF = stall_raw[4];
    assign stallD = stall_raw[3] & ~flush_raw[3];
    assign stallE = stall_raw[2] & ~flush_raw[2];
    assign stallM = stall_raw[1] & ~flush_raw[1];
    assign stallW = stall_raw[0] & ~flush_raw[0];
    assign {flushD, flushE, flushM, flushW} = flush_raw;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (miss && exceptM)
                    state_d = ST_FLUSH_PEND;
                else if (div_load)
                    state_d = ST_DIV_BUSY;
            end
            ST_DIV_BUSY: begin
                if (exceptM)
                    state_d = miss ? ST_FLUSH_PEND : ST_IDLE;
                else if (div_done)
                    state_d = ST_IDLE;
            end
            ST_FLUSH_PEND: begin
                if (!miss)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb stall_cycles_d = stall_cycles_q + 32'(stallF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cycles_q <= '0;
        else
            stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: vector table plus multi-cycle sequences.
module tb_pipeline_stall_ctrl;
    localparam int DC = 34;

    typedef struct packed {
        logic       i_stall, d_stall, mem_readE;
        logic [4:0] rtE, rsD, rtD;
        logic       div_startE, mispred, exceptM;
    } vin_t;

    typedef struct {
        vin_t        in;
        logic [10:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [10:0] exp;
        string       name;
    } sb_t;

    // {stallF..W, flushD..W, div_busy, div_done}
    localparam logic [10:0] O_NONE  = 11'b00000_0000_00;
    localparam logic [10:0] O_MISS  = 11'b11111_0000_00;
    localparam logic [10:0] O_MISSB = 11'b11111_0000_10;
    localparam logic [10:0] O_LU    = 11'b11000_0100_00;
    localparam logic [10:0] O_MP    = 11'b00000_1000_00;
    localparam logic [10:0] O_EXC   = 11'b00000_1111_00;
    localparam logic [10:0] O_EXCB  = 11'b00000_1111_10;
    localparam logic [10:0] O_DIV   = 11'b11100_0010_10;
    localparam logic [10:0] O_DONE  = 11'b00000_0000_11;

    logic clk = 1'b0, rst = 1'b0;
    logic i_stall, d_stall, mem_readE, div_startE, branch_mispredE, exceptM;
    logic [4:0] rtE, rsD, rtD;
    logic stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW;
    logic div_busy, div_done;
    logic [31:0] stall_cycles;

    int total = 0, bad = 0;
    sb_t sbq[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.DIV_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .d_stall(d_stall),
        .mem_readE(mem_readE), .rtE(rtE), .rsD(rsD), .rtD(rtD),
        .div_startE(div_startE), .branch_mispredE(branch_mispredE), .exceptM(exceptM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .div_busy(div_busy), .div_done(div_done), .stall_cycles(stall_cycles)
    );

    function automatic vin_t vi(logic is, logic ds, logic mr, logic [4:0] te, logic [4:0] sd,
                                logic [4:0] td, logic dv, logic mp, logic ex);
        vin_t v;
        v = '{is, ds, mr, te, sd, td, dv, mp, ex};
        return v;
    endfunction

    function automatic logic [10:0] obs();
        return {stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW,
                div_busy, div_done};
    endfunction

    task automatic drive(input vin_t v);
        i_stall = v.i_stall; d_stall = v.d_stall; mem_readE = v.mem_readE;
        rtE = v.rtE; rsD = v.rsD; rtD = v.rtD;
        div_startE = v.div_startE; branch_mispredE = v.mispred; exceptM = v.exceptM;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic check_pop();
        sb_t e;
        e = sbq.pop_front();
        chk(e.name, 32'(obs()), 32'(e.exp));
    endtask

    task automatic step(input vin_t v, input logic [10:0] exp, input string name);
        sb_t e;
        @(posedge clk); #1;
        drive(v);
        e.exp = exp; e.name = name;
        sbq.push_back(e);
        @(negedge clk);
        check_pop();
    endtask

    initial begin
        vin_t z;
        z = '0;
        drive(z);

        // reset state and combinational outputs during reset
        #2;
        chk("rst_outs", 32'(obs()), 32'(O_NONE));
        chk("rst_perf", stall_cycles, 32'd0);
        i_stall = 1'b1; #1;
        chk("rst_miss_comb", 32'(obs()), 32'(O_MISS));
        i_stall = 1'b0;
        @(negedge clk); rst = 1'b1;

        // stalled-cycle counter
        for (int k = 0; k < 3; k++) step(vi(1,0,0,0,0,0,0,0,0), O_MISS, "perf_miss");
        step(z, O_NONE, "perf_idle");
`ifdef STALL_PERF_CNT_EN
        chk("perf_cnt", stall_cycles, 32'd3);
`else
        chk("perf_cnt", stall_cycles, 32'd0);
`endif

        // single-cycle combinational vectors, FSM stays in IDLE
        tbl.push_back('{z,                          O_NONE, "v_zero"});
        tbl.push_back('{vi(1,0,0,0,0,0,0,0,0),      O_MISS, "v_istall"});
        tbl.push_back('{vi(0,1,0,0,0,0,0,0,0),      O_MISS, "v_dstall"});
        tbl.push_back('{vi(0,0,1,5,5,0,0,0,0),      O_LU,   "v_lu_rs"});
        tbl.push_back('{vi(0,0,1,5,3,5,0,0,0),      O_LU,   "v_lu_rt"});
        tbl.push_back('{vi(0,0,1,31,31,0,0,0,0),    O_LU,   "v_lu_r31"});
        tbl.push_back('{vi(0,0,1,0,0,0,0,0,0),      O_NONE, "v_lu_r0"});
        tbl.push_back('{vi(0,0,1,5,6,7,0,0,0),      O_NONE, "v_lu_nomatch"});
        tbl.push_back('{vi(0,0,0,5,5,5,0,0,0),      O_NONE, "v_lu_noload"});
        tbl.push_back('{vi(0,0,0,0,0,0,0,1,0),      O_MP,   "v_mispred"});
        tbl.push_back('{vi(0,0,0,0,0,0,0,0,1),      O_EXC,  "v_except"});
        tbl.push_back('{vi(0,0,1,5,5,0,0,1,0),      O_LU,   "v_lu_mp"});
        tbl.push_back('{vi(0,1,1,5,5,0,0,0,0),      O_MISS, "v_lu_miss"});
        tbl.push_back('{vi(0,0,1,5,5,0,0,1,1),      O_EXC,  "v_exc_lu_mp"});
        tbl.push_back('{vi(1,0,0,0,0,0,0,1,0),      O_MISS, "v_mp_miss"});
        foreach (tbl[i]) step(tbl[i].in, tbl[i].exp, tbl[i].name);

        // load-use bubble lasts exactly one cycle
        step(vi(0,0,1,5,5,0,0,0,0), O_LU, "lu_bubble");
        step(z, O_NONE, "lu_release");

        // full divide; div_startE still high on the done cycle starts nothing
        step(vi(0,0,0,0,0,0,1,0,0), O_NONE, "div_start");
        for (int k = 1; k < DC; k++) step(z, O_DIV, "div_busy");
        step(vi(0,0,0,0,0,0,1,0,0), O_DONE, "div_done");
        step(vi(0,0,0,0,0,0,1,0,0), O_NONE, "div_idle_pass");

        // that start begins a new divide, stretched 3 cycles by d_stall
        for (int k = 1; k <= DC + 3; k++) begin
            if (k >= 5 && k <= 7)    step(vi(0,1,0,0,0,0,0,0,0), O_MISSB, "div_miss");
            else if (k == DC + 3)    step(z, O_DONE, "div_done_late");
            else                     step(z, O_DIV, "div_busy_m");
        end
        step(z, O_NONE, "div_after");

        // exception during a miss waits, then flushes once
        step(vi(1,0,0,0,0,0,0,0,1), O_MISS, "exc_miss");
        for (int k = 0; k < 4; k++) step(vi(1,0,0,0,0,0,0,0,0), O_MISS, "exc_hold");
        step(z, O_EXC, "exc_flush");
        step(z, O_NONE, "exc_after");

        // exception aborts divide, with and without a concurrent miss
        step(vi(0,0,0,0,0,0,1,0,0), O_NONE, "abt_start");
        step(z, O_DIV, "abt_busy");
        step(vi(0,0,0,0,0,0,0,0,1), O_EXCB, "abt_exc");
        step(z, O_NONE, "abt_idle");
        step(vi(0,0,0,0,0,0,1,0,0), O_NONE, "abtm_start");
        step(z, O_DIV, "abtm_busy");
        step(vi(0,1,0,0,0,0,0,0,1), O_MISSB, "abtm_exc");
        step(z, O_EXC, "abtm_flush");
        step(z, O_NONE, "abtm_idle");

        // reset mid-divide
        step(vi(0,0,0,0,0,0,1,0,0), O_NONE, "rd_start");
        for (int k = 1; k < 10; k++) step(z, O_DIV, "rd_busy");
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("rd_busy_clr", 32'(div_busy), 32'd0);
        @(negedge clk); rst = 1'b1;
        for (int k = 0; k < DC + 4; k++) step(z, O_NONE, "rd_no_done");

        // reset while a flush is pending
        step(vi(1,0,0,0,0,0,0,0,1), O_MISS, "rp_exc");
        step(vi(1,0,0,0,0,0,0,0,0), O_MISS, "rp_hold");
        @(posedge clk); #1;
        rst = 1'b0; #1; rst = 1'b1;
        step(z, O_NONE, "rp_no_flush");
        step(z, O_NONE, "rp_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
